cluster_hart_scheduler: RTL and testbench

//  Time-slice scheduler for the harts of the CPU cluster sharing one MMU and one memory interconnect port.

---
 rtl/cluster_hart_scheduler_pkg.sv | 13 +
 rtl/cluster_hart_scheduler_rr_next_hart.sv | 36 +++
 rtl/cluster_hart_scheduler.sv | 157 +++++++++++++++
 tb/tb_cluster_hart_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_hart_scheduler_pkg.sv
// Shared definitions for the cluster hart scheduler: FSM state codes and the
// default time-slice length.
package cluster_hart_scheduler_pkg;

    typedef enum logic [1:0] {
        HS_RUN    = 2'd0,
        HS_DRAIN  = 2'd1,
        HS_SWITCH = 2'd2
    } hs_state_e;

    localparam int HS_DEFAULT_QUANTUM = 1024;

endpackage

// File: rtl/cluster_hart_scheduler_rr_next_hart.sv
// Combinational wrap-around first-set finder: returns the first set bit of mask
// scanning start+1 .. N-1, 0 .. start-1 (start itself is never chosen).
module rr_next_hart #(
    parameter int N     = 1,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] idx_s;
    logic             found_s;
    int               pos_s;

    // priority scan in wrap order; the first hit wins
    always_comb begin
        idx_s   = {SEL_W{1'b0}};
        found_s = 1'b0;
        pos_s   = 0;
        for (int k = 1; k < N; k++) begin
            pos_s = (int'(start) + k) % N;
            if (!found_s && mask[pos_s]) begin
                idx_s   = SEL_W'(pos_s);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign idx   = idx_s;
    assign found = found_s;

endmodule

// File: rtl/cluster_hart_scheduler.sv
// Time-slice scheduler for harts sharing the cluster MMU / interconnect port.
// Optional interrupt-priority selection is enabled by HART_SCHED_IRQ_PRIO_EN.
module cluster_hart_scheduler
    import cluster_hart_scheduler_pkg::*;
#(
    parameter int N_HARTS = 1,
    parameter int QUANTUM = HS_DEFAULT_QUANTUM,
    parameter int SEL_W   = ($clog2(N_HARTS) > 0) ? $clog2(N_HARTS) : 1,
    localparam int CNT_W  = $clog2(QUANTUM + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               w_mode_is_cpu,
    input  logic               w_next_mode_is_mc,
    input  logic               w_safe_point,
    input  logic               w_shared_busy,
    input  logic [N_HARTS-1:0] w_hart_runnable,
    input  logic [N_HARTS-1:0] w_hart_irq,
    output logic [SEL_W-1:0]   w_hart_sel,
    output logic [N_HARTS-1:0] w_hart_busy,
    output logic               w_switch,
    output logic [CNT_W-1:0]   w_slice_cnt
);

    hs_state_e          state_r;
    hs_state_e          state_nxt_s;
    logic [SEL_W-1:0]   sel_r;
    logic [SEL_W-1:0]   next_sel_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               latch_s;
    logic               cnt_sat_s;
    logic               expired_s;
    logic               irq_force_s;
    logic [SEL_W-1:0]   rr_idx_s;
    logic               rr_found_s;
    logic [SEL_W-1:0]   cand_s;
    logic               has_cand_s;
    logic [N_HARTS-1:0] busy_s;

    rr_next_hart #(
        .N     (N_HARTS),
        .SEL_W (SEL_W)
    ) u_rr_runnable (
        .mask  (w_hart_runnable),
        .start (sel_r),
        .idx   (rr_idx_s),
        .found (rr_found_s)
    );

`ifdef HART_SCHED_IRQ_PRIO_EN
    logic [SEL_W-1:0] irq_idx_s;
    logic             irq_found_s;

    rr_next_hart #(
        .N     (N_HARTS),
        .SEL_W (SEL_W)
    ) u_rr_irq (
        .mask  (w_hart_runnable & w_hart_irq),
        .start (sel_r),
        .idx   (irq_idx_s),
        .found (irq_found_s)
    );

    // an interrupting hart pre-empts the slice unless the owner is also interrupted
    assign cand_s      = irq_found_s ? irq_idx_s : rr_idx_s;
    assign irq_force_s = irq_found_s & ~w_hart_irq[sel_r];
`else
    logic unused_irq_s;

    assign cand_s       = rr_idx_s;
    assign irq_force_s  = 1'b0;
    assign unused_irq_s = ^w_hart_irq;
`endif

    // any runnable irq hart is also runnable, so round-robin "found" covers both
    assign has_cand_s = rr_found_s;
    assign cnt_sat_s  = (cnt_r == CNT_W'(QUANTUM));
    assign expired_s  = cnt_sat_s | ~w_hart_runnable[sel_r] | irq_force_s;

    // next-state decode; a switch is only committed at a safe point in CPU mode
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        case (state_r)
            HS_RUN: begin
                if (expired_s && has_cand_s) begin
                    state_nxt_s = HS_DRAIN;
                end else begin
                    state_nxt_s = HS_RUN;
                end
            end
            HS_DRAIN: begin
                if (!has_cand_s) begin
                    state_nxt_s = HS_RUN;
                end else if (w_safe_point && w_mode_is_cpu && !w_next_mode_is_mc) begin
                    state_nxt_s = HS_SWITCH;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = HS_DRAIN;
                end
            end
            HS_SWITCH: begin
                state_nxt_s = HS_RUN;
            end
            default: begin
                state_nxt_s = HS_RUN;
            end
        endcase
    end

    // state, owner select, pending select and slice counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= HS_RUN;
            sel_r      <= {SEL_W{1'b0}};
            next_sel_r <= {SEL_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                HS_SWITCH: begin
                    sel_r <= next_sel_r;
                    cnt_r <= {CNT_W{1'b0}};
                end
                HS_RUN, HS_DRAIN: begin
                    if (w_mode_is_cpu && !cnt_sat_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
            if (latch_s) begin
                next_sel_r <= cand_s;
            end else begin
                next_sel_r <= next_sel_r;
            end
        end
    end

    // during SWITCH every hart is stalled so the old hart's MMU request drains cleanly
    always_comb begin
        busy_s = {N_HARTS{1'b1}};
        for (int g = 0; g < N_HARTS; g++) begin
            busy_s[g] = (SEL_W'(g) != sel_r) | (state_r == HS_SWITCH) | w_shared_busy;
        end
    end

    assign w_hart_busy = busy_s;
    assign w_hart_sel  = sel_r;
    assign w_switch    = (state_r == HS_SWITCH);
    assign w_slice_cnt = cnt_r;

endmodule

// File: tb/tb_cluster_hart_scheduler.sv
// Scoreboard bench for cluster_hart_scheduler: expected switches are queued by
// the stimulus and checked by per-instance monitors when w_switch pulses.
module tb_cluster_hart_scheduler;

    typedef struct {
        int sel;
        int cnt;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic cpu, mc, safe, shbusy;
    logic rst1, rst2, rst4;

    logic [0:0] run1, irq1, sel1, busy1, cnt1;
    logic       sw1;
    logic [1:0] run2, irq2, busy2;
    logic [0:0] sel2;
    logic       sw2;
    logic [3:0] cnt2;
    logic [3:0] run4, irq4, busy4, cnt4;
    logic [1:0] sel4;
    logic       sw4;

    exp_t q2[$];
    exp_t q4[$];
    exp_t cur2, cur4;
    bit   pend2 = 1'b0;
    bit   pend4 = 1'b0;
    bit   seen1 = 1'b0;
    int   lat;

    cluster_hart_scheduler #(.N_HARTS(1), .QUANTUM(1)) dut1 (
        .CLK(CLK), .RST(rst1), .w_mode_is_cpu(cpu), .w_next_mode_is_mc(mc),
        .w_safe_point(safe), .w_shared_busy(shbusy), .w_hart_runnable(run1),
        .w_hart_irq(irq1), .w_hart_sel(sel1), .w_hart_busy(busy1),
        .w_switch(sw1), .w_slice_cnt(cnt1));

    cluster_hart_scheduler #(.N_HARTS(2), .QUANTUM(8)) dut2 (
        .CLK(CLK), .RST(rst2), .w_mode_is_cpu(cpu), .w_next_mode_is_mc(mc),
        .w_safe_point(safe), .w_shared_busy(shbusy), .w_hart_runnable(run2),
        .w_hart_irq(irq2), .w_hart_sel(sel2), .w_hart_busy(busy2),
        .w_switch(sw2), .w_slice_cnt(cnt2));

    cluster_hart_scheduler #(.N_HARTS(4), .QUANTUM(8)) dut4 (
        .CLK(CLK), .RST(rst4), .w_mode_is_cpu(cpu), .w_next_mode_is_mc(mc),
        .w_safe_point(safe), .w_shared_busy(shbusy), .w_hart_runnable(run4),
        .w_hart_irq(irq4), .w_hart_sel(sel4), .w_hart_busy(busy4),
        .w_switch(sw4), .w_slice_cnt(cnt4));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sw(input int which, input int budget, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < budget) begin
            @(negedge CLK);
            cycles++;
            hit = (which == 2) ? sw2 : sw4;
        end
        if (!hit) begin
            n_checks++;
            n_fail++;
            $display("FAIL sw_timeout dut%0d: no switch within %0d cycles", which, budget);
        end
    endtask

    // monitor for the 2-hart instance
    always @(negedge CLK) begin
        if (pend2) begin
            check("sw2_new_sel", int'(sel2), cur2.sel);
            check("sw2_cnt_clear", int'(cnt2), 0);
            check("sw2_busy_after", int'(busy2), 3 & ~(1 << cur2.sel));
        end
        if (sw2) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sw2_unexpected: switch pulse, none expected (sel %0d)", sel2);
                pend2 <= 1'b0;
            end else begin
                check("sw2_busy_switch", int'(busy2), 3);
                if (q2[0].cnt >= 0) check("sw2_cnt_at_switch", int'(cnt2), q2[0].cnt);
                cur2  <= q2[0];
                q2.delete(0);
                pend2 <= 1'b1;
            end
        end else begin
            pend2 <= 1'b0;
        end
    end

    // monitor for the 4-hart instance
    always @(negedge CLK) begin
        if (pend4) begin
            check("sw4_new_sel", int'(sel4), cur4.sel);
            check("sw4_cnt_clear", int'(cnt4), 0);
            check("sw4_busy_after", int'(busy4), 15 & ~(1 << cur4.sel));
        end
        if (sw4) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sw4_unexpected: switch pulse, none expected (sel %0d)", sel4);
                pend4 <= 1'b0;
            end else begin
                check("sw4_busy_switch", int'(busy4), 15);
                if (q4[0].cnt >= 0) check("sw4_cnt_at_switch", int'(cnt4), q4[0].cnt);
                cur4  <= q4[0];
                q4.delete(0);
                pend4 <= 1'b1;
            end
        end else begin
            pend4 <= 1'b0;
        end
    end

    // single-hart instance must never switch
    always @(negedge CLK) begin
        if (sw1) seen1 <= 1'b1;
    end

    initial begin
        cpu = 1'b1; mc = 1'b0; safe = 1'b1; shbusy = 1'b0;
        rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
        run1 = 1'b1; irq1 = 1'b0;
        run2 = 2'b11; irq2 = 2'b00;
        run4 = 4'b1111; irq4 = 4'b0000;
        repeat (2) @(negedge CLK);

        // reset state
        check("rst_sel", int'(sel2), 0);
        check("rst_busy", int'(busy2), 2);
        check("rst_switch", int'(sw2), 0);
        check("rst_cnt", int'(cnt2), 0);
        shbusy = 1'b1;
        #1;
        check("rst_busy_shared", int'(busy2), 3);
        shbusy = 1'b0;
        rst1 = 1'b0;

        // quantum expiry, two consecutive switches
        rst2 = 1'b0;
        q2.push_back('{1, 8});
        wait_sw(2, 30, lat);
        check("t2_first_latency", lat, 10);
        q2.push_back('{0, 8});
        wait_sw(2, 30, lat);
        check("t2_period", lat, 11);
        @(negedge CLK);

        // DRAIN held by missing safe point, then by pending MC mode
        safe = 1'b0;
        rst2 = 1'b1;
        repeat (2) @(negedge CLK);
        rst2 = 1'b0;
        repeat (29) @(negedge CLK);
        check("t4_busy_hold", int'(busy2), 2);
        check("t4_cnt_sat", int'(cnt2), 8);
        check("t4_sel_hold", int'(sel2), 0);
        mc = 1'b1;
        safe = 1'b1;
        repeat (5) @(negedge CLK);
        check("t4_mc_busy", int'(busy2), 2);
        check("t4_mc_sel", int'(sel2), 0);
        q2.push_back('{1, 8});
        mc = 1'b0;
        wait_sw(2, 5, lat);
        check("t4_release_latency", lat, 1);
        @(negedge CLK);

        // reset during the SWITCH cycle discards the pending switch
        rst2 = 1'b1;
        repeat (2) @(negedge CLK);
        rst2 = 1'b0;
        q2.push_back('{0, 8});
        wait_sw(2, 30, lat);
        check("t5_latency", lat, 10);
        rst2 = 1'b1;
        @(negedge CLK);
        check("t5_switch", int'(sw2), 0);
        check("t5_sel", int'(sel2), 0);
        check("t5_cnt", int'(cnt2), 0);
        check("t5_busy", int'(busy2), 2);

        // parked harts are skipped, selection wraps
        run4 = 4'b1001;
        rst4 = 1'b0;
        cpu  = 1'b0;
        repeat (3) @(negedge CLK);
        check("t3_cnt_mc_mode", int'(cnt4), 0);
        cpu = 1'b1;
        repeat (2) @(negedge CLK);
        check("t3_cnt_run", int'(cnt4), 2);
        run4 = 4'b1000;
        q4.push_back('{3, -1});
        wait_sw(4, 10, lat);
        check("t3_park_latency", lat, 2);
        @(negedge CLK);
        run4 = 4'b0001;
        q4.push_back('{0, -1});
        wait_sw(4, 10, lat);
        check("t3_wrap_latency", lat, 2);
        @(negedge CLK);
        run4 = 4'b0000;
        repeat (15) @(negedge CLK);
        check("t3_none_runnable_sel", int'(sel4), 0);
        run4 = 4'b0001;
        repeat (15) @(negedge CLK);
        check("t3_alone_sel", int'(sel4), 0);
        check("t3_alone_cnt", int'(cnt4), 8);

        // interrupt priority (or plain round-robin in the default build)
        rst4 = 1'b1;
        run4 = 4'b1111;
        repeat (2) @(negedge CLK);
        rst4 = 1'b0;
        repeat (3) @(negedge CLK);
        check("t6_cnt_before_irq", int'(cnt4), 3);
        irq4 = 4'b0100;
`ifdef HART_SCHED_IRQ_PRIO_EN
        q4.push_back('{2, 5});
        wait_sw(4, 20, lat);
        check("t6_irq_latency", lat, 2);
`else
        q4.push_back('{1, 8});
        wait_sw(4, 20, lat);
        check("t6_rr_latency", lat, 7);
`endif
        @(negedge CLK);
        irq4 = 4'b0000;
        @(negedge CLK);

        // end-of-run checks
        check("q2_drained", q2.size(), 0);
        check("q4_drained", q4.size(), 0);
        check("n1_no_switch", int'(seen1), 0);
        check("n1_sel", int'(sel1), 0);
        check("n1_cnt_sat", int'(cnt1), 1);
        check("n1_busy", int'(busy1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
